int_stim_gen: RTL and testbench
===============================

Name: int_stim_gen

Overview:
- Parametrised, synthesisable interrupt stimulus generator for the pipelined MIPS CPU test environment. Generalises the single-shot "fire when macroscopic PC hits target, clear on write to 0x7f20" scheme.
- Supports N independent channels, each with its own target PC and acknowledge address.
- Each channel can fire multiple times, with a re-arm gap and an optional acknowledge timeout.
- Sits beside the CPU in the bench or on the board. It drives the CPU interrupt inputs and snoops the CPU's macroscopic PC and interrupt-controller write port.

Parameters:
- N_CH, 1, number of interrupt channels (1..8).
- TARGETS, {32'h00003010}, packed N_CH*32 target PCs; channel ch uses bits [32*ch+31:32*ch].
- ACK_BASE, 32'h00007f20, acknowledge address of channel 0; channel ch acknowledges at ACK_BASE + 4*ch.
- MAX_FIRES, 1, firings per channel before retiring; 0 = unlimited.
- REARM_GAP, 0, cycles a channel waits after deassert before it may fire again.
- TIMEOUT, 0, cycles an assertion may stay unacknowledged before forced deassert; 0 = never.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global enable; when low, no new firing starts (active assertions unaffected).
- macroscopic_pc  in  32  CPU macroscopic PC; bits [1:0] ignored.
- m_int_addr  in  32  CPU write address toward the interrupt controller; bits [1:0] ignored.
- m_int_byteen  in  4  byte enables of that write; any bit set = write valid.
- interrupt  out  N_CH  per-channel interrupt request, registered.
- interrupt_any  out  1  OR of interrupt, registered.
- fire_total  out  16  saturating total of firings, all channels.
- timeout_err  out  N_CH  sticky per-channel flag: assertion forced low by TIMEOUT.

Behaviour:
- Reset (synchronous, active-high) puts every channel in IDLE, with:
  - fire count 0, armed = 1, timers 0;
  - interrupt = 0, interrupt_any = 0, fire_total = 0, timeout_err = 0.
- Reset mid-assertion drops interrupt on the next edge.
- Per-channel signals:
  - hit = (macroscopic_pc & ~3) == TARGET[ch].
  - ack = |m_int_byteen && (m_int_addr & ~3) == ACK_BASE + 4*ch.
- armed: cleared when the channel fires; set on any edge where hit = 0. This stops re-firing while the PC stalls on the target.
- States and transitions:
  - IDLE: if enable && hit && armed && (MAX_FIRES == 0 || fires < MAX_FIRES), go to ASSERT. On that edge: interrupt[ch] <= 1, fires++, fire_total++ (saturates at 16'hFFFF), timer <= 0. The line rises 1 cycle after the matching PC is sampled.
  - ASSERT:
    - If ack: interrupt[ch] <= 0 and go to POST.
    - Else if TIMEOUT != 0 && timer == TIMEOUT-1: interrupt[ch] <= 0, timeout_err[ch] <= 1, go to POST.
    - Else timer++.
    - An ack and a timeout on the same edge count as an ack: no error flag.
  - POST:
    - If REARM_GAP == 0, resolve on the same edge as the deassert.
    - Otherwise wait exactly REARM_GAP cycles with interrupt low.
    - Then go to DONE if MAX_FIRES != 0 && fires == MAX_FIRES, else to IDLE.
  - DONE: terminal until reset; hit and ack are ignored.
- interrupt_any is registered as the OR of the next-state interrupt values, so it rises and falls on the same edges as the channel lines.
- Acks in IDLE, POST or DONE are ignored. Writes to another channel's ack address never affect this channel.
- Channels run independently. Several may assert on the same edge; fire_total then increases by the number of channels firing.
- A hit while enable = 0 does not fire and does not clear armed. If enable rises while the PC still holds the target, the channel fires.

Test Plan:
- Default parameters: PC steps 0x3000, 0x3004 … 0x3010 → interrupt = 1 on the edge after 0x3010 is sampled. A write to 0x7f20 with byteen 4'b0001 → interrupt = 0 next edge. PC revisits 0x3010 → no second firing; fire_total = 1.
- MAX_FIRES = 3, REARM_GAP = 2, PC held at 0x3010 across the ack → no re-fire until the PC leaves and returns. Exactly 3 firings, each separated by at least 2 low cycles. Then DONE; fire_total = 3.
- TIMEOUT = 5, no ack → interrupt high for exactly 5 cycles, then low; timeout_err[0] = 1 and stays set. A write to 0x7f20 afterwards has no effect.
- N_CH = 2, TARGETS = {0x3020, 0x3010} (channel 0 = 0x3010, channel 1 = 0x3020):
  - PC passes both targets → both lines assert; interrupt_any = 1.
  - Ack at 0x7f24 → only interrupt[1] clears; interrupt_any stays 1 until the ack at 0x7f20.
- Ack and timeout on the same edge (ack written at cycle TIMEOUT-1) → deasserted, timeout_err = 0. Reset pulsed while asserted → all outputs 0 on the next edge, and the channel can fire again.

Source files
------------

// File: rtl/int_stim_gen.sv
// int_stim_gen: multi-channel interrupt stimulus generator.
// Fires on PC match, clears on ack write, optional re-arm gap and timeout.
module int_stim_gen #(
  parameter int                 N_CH      = 1,
  parameter logic [N_CH*32-1:0] TARGETS   = 32'h00003010,
  parameter logic [31:0]        ACK_BASE  = 32'h00007f20,
  parameter int                 MAX_FIRES = 1,
  parameter int                 REARM_GAP = 0,
  parameter int                 TIMEOUT   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [31:0]     macroscopic_pc,
  input  logic [31:0]     m_int_addr,
  input  logic [3:0]      m_int_byteen,
  output logic [N_CH-1:0] interrupt,
  output logic            interrupt_any,
  output logic [15:0]     fire_total,
  output logic [N_CH-1:0] timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_POST,
    S_DONE
  } state_t;

  logic [N_CH-1:0] fire_v;
  logic [N_CH-1:0] int_nxt;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    localparam logic [31:0] TGT = TARGETS[32*ch +: 32];
    localparam logic [31:0] ACK_ADDR = ACK_BASE + 32'(4 * ch);

    state_t      state;
    logic        armed;
    logic [31:0] fires;
    logic [31:0] timer;
    logic [31:0] gap;
    logic        int_q;
    logic        terr_q;
    logic        hit;
    logic        ack;
    logic        fire;
    logic        tmo;
    logic        clr;
    logic        last;

    always_comb begin
      hit  = (macroscopic_pc & ~32'd3) == TGT;
      ack  = (|m_int_byteen)
          && ((m_int_addr & ~32'd3) == ACK_ADDR);
      fire = (state == S_IDLE) && enable && hit && armed
          && (MAX_FIRES == 0 || fires < 32'(MAX_FIRES));
      // ack wins over a timeout landing on the same edge
      tmo  = (state == S_ASSERT) && !ack && (TIMEOUT != 0)
          && (timer == 32'(TIMEOUT - 1));
      clr  = (state == S_ASSERT) && (ack || tmo);
      last = (MAX_FIRES != 0) && (fires == 32'(MAX_FIRES));
    end

    assign fire_v[ch]      = fire;
    assign int_nxt[ch]     = fire | (int_q & ~clr);
    assign interrupt[ch]   = int_q;
    assign timeout_err[ch] = terr_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= S_IDLE;
        armed  <= 1'b1;
        fires  <= '0;
        timer  <= '0;
        gap    <= '0;
        int_q  <= 1'b0;
        terr_q <= 1'b0;
      end else begin
        // armed blocks re-firing while the PC stalls on target
        if (fire) armed <= 1'b0;
        else if (!hit) armed <= 1'b1;

        unique case (state)
          S_IDLE: begin
            if (fire) begin
              state <= S_ASSERT;
              int_q <= 1'b1;
              fires <= fires + 32'd1;
              timer <= '0;
            end
          end
          S_ASSERT: begin
            if (clr) begin
              int_q <= 1'b0;
              gap   <= '0;
              if (tmo) terr_q <= 1'b1;
              if (REARM_GAP == 0)
                state <= last ? S_DONE : S_IDLE;
              else
                state <= S_POST;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          S_POST: begin
            if (gap == 32'(REARM_GAP - 1))
              state <= last ? S_DONE : S_IDLE;
            else
              gap <= gap + 32'd1;
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [3:0]  n_fire;
  logic [16:0] sum;

  always_comb begin
    n_fire = '0;
    for (int i = 0; i < N_CH; i++)
      n_fire = n_fire + 4'(fire_v[i]);
    sum = {1'b0, fire_total} + 17'(n_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_any <= 1'b0;
      fire_total    <= '0;
    end else begin
      interrupt_any <= |int_nxt;
      fire_total    <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

endmodule

// File: tb/tb_int_stim_gen.sv
// tb_int_stim_gen: four configurations driven by shared random stimulus,
// checked against an event-level model through a scoreboard queue.
module tb_int_stim_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;

  always #5 clk = ~clk;

  logic        int_a, any_a, te_a;
  logic [15:0] tot_a;
  logic        int_b, any_b, te_b;
  logic [15:0] tot_b;
  logic        int_c, any_c, te_c;
  logic [15:0] tot_c;
  logic [1:0]  int_d, te_d;
  logic        any_d;
  logic [15:0] tot_d;

  int_stim_gen u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(int_a), .interrupt_any(any_a),
    .fire_total(tot_a), .timeout_err(te_a)
  );

  int_stim_gen #(.MAX_FIRES(3), .REARM_GAP(2)) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(int_b), .interrupt_any(any_b),
    .fire_total(tot_b), .timeout_err(te_b)
  );

  int_stim_gen #(.MAX_FIRES(0), .REARM_GAP(1), .TIMEOUT(5)) u_c (
    .clk(clk), .reset(reset), .enable(enable),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(int_c), .interrupt_any(any_c),
    .fire_total(tot_c), .timeout_err(te_c)
  );

  int_stim_gen #(
    .N_CH(2), .TARGETS({32'h00003020, 32'h00003010}),
    .MAX_FIRES(0), .REARM_GAP(0), .TIMEOUT(6)
  ) u_d (
    .clk(clk), .reset(reset), .enable(enable),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(int_d), .interrupt_any(any_d),
    .fire_total(tot_d), .timeout_err(te_d)
  );

  typedef struct packed {
    logic [1:0]  intr;
    logic        any;
    logic [15:0] tot;
    logic [1:0]  terr;
  } obs_t;
  typedef obs_t [3:0] snap_t;

  snap_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          nch[4]  = '{1, 1, 1, 2};
  int          maxf[4] = '{1, 3, 0, 0};
  int          gapp[4] = '{0, 2, 1, 0};
  int          tmo[4]  = '{0, 0, 5, 6};
  logic [31:0] tgt1    = 32'h00003020;

  int  edge_no = 0;
  bit  m_as[4][2];
  int  m_fe[4][2];
  int  m_ready[4][2];
  int  m_fires[4][2];
  bit  m_arm[4][2];
  bit  m_terr[4][2];
  int  m_total[4];

  task automatic model_edge(input bit r, input bit en,
                            input logic [31:0] pc,
                            input logic [31:0] ad,
                            input logic [3:0] be);
    logic [31:0] t;
    bit hit, ack, fired;
    for (int k = 0; k < 4; k++) begin
      if (r) m_total[k] = 0;
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          m_as[k][c] = 0; m_fe[k][c] = 0;
          m_ready[k][c] = 0; m_fires[k][c] = 0;
          m_arm[k][c] = 1; m_terr[k][c] = 0;
        end else if (c < nch[k]) begin
          t = (c == 0) ? 32'h00003010 : tgt1;
          hit = (pc & ~32'd3) == t;
          ack = (be != 0)
             && ((ad & ~32'd3) == 32'h00007f20 + 32'(4 * c));
          fired = 0;
          if (m_as[k][c]) begin
            if (ack || (tmo[k] != 0
                && edge_no == m_fe[k][c] + tmo[k])) begin
              if (!ack) m_terr[k][c] = 1;
              m_as[k][c] = 0;
              m_ready[k][c] = edge_no + gapp[k] + 1;
            end
          end else if (en && hit && m_arm[k][c]
                       && edge_no >= m_ready[k][c]
                       && (maxf[k] == 0
                           || m_fires[k][c] < maxf[k])) begin
            fired = 1;
            m_as[k][c] = 1;
            m_fe[k][c] = edge_no;
            m_fires[k][c]++;
            if (m_total[k] < 65535) m_total[k]++;
          end
          if (fired) m_arm[k][c] = 0;
          else if (!hit) m_arm[k][c] = 1;
        end
      end
    end
    edge_no++;
  endtask

  function automatic snap_t snapshot();
    snap_t s;
    for (int k = 0; k < 4; k++) begin
      s[k].intr = {m_as[k][1], m_as[k][0]};
      s[k].any  = m_as[k][0] | m_as[k][1];
      s[k].tot  = 16'(m_total[k]);
      s[k].terr = {m_terr[k][1], m_terr[k][0]};
    end
    return s;
  endfunction

  task automatic step(input bit r, input bit en,
                      input logic [31:0] pc,
                      input logic [31:0] ad,
                      input logic [3:0] be);
    @(negedge clk);
    reset = r; enable = en;
    macroscopic_pc = pc; m_int_addr = ad; m_int_byteen = be;
    model_edge(r, en, pc, ad, be);
    q.push_back(snapshot());
  endtask

  task automatic chk(input string nm, input int k,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h",
               nm, k, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a[0] = {1'b0, int_a, any_a, tot_a, 1'b0, te_a};
        a[1] = {1'b0, int_b, any_b, tot_b, 1'b0, te_b};
        a[2] = {1'b0, int_c, any_c, tot_c, 1'b0, te_c};
        a[3] = {int_d, any_d, tot_d, te_d};
        for (int k = 0; k < 4; k++) begin
          chk("interrupt", k, 16'(a[k].intr), 16'(e[k].intr));
          chk("interrupt_any", k, 16'(a[k].any), 16'(e[k].any));
          chk("fire_total", k, a[k].tot, e[k].tot);
          chk("timeout_err", k, 16'(a[k].terr), 16'(e[k].terr));
        end
      end
    end
  end

  logic [31:0] pcs[8] = '{32'h3000, 32'h3004, 32'h3008,
                          32'h300c, 32'h3010, 32'h3014,
                          32'h3020, 32'h3024};
  logic [31:0] acks[4] = '{32'h7f20, 32'h7f24,
                           32'h7f28, 32'h7f1c};

  initial begin : stim
    logic [31:0] pc, ad;
    logic [3:0]  be;
    bit          en, r;
    reset = 1'b1; enable = 1'b0;
    macroscopic_pc = '0; m_int_addr = '0; m_int_byteen = '0;
    step(1, 1, 32'h0, 32'h0, 4'h0);
    step(1, 1, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 32'h3000 + 32'(4 * i), 32'h0, 4'h0);
    step(0, 1, 32'h3010, 32'h7f20, 4'b0001);
    step(0, 1, 32'h3010, 32'h0, 4'h0);
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    step(0, 1, 32'h3010, 32'h0, 4'h0);
    step(0, 1, 32'h3020, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 32'h3020, 32'h0, 4'h0);
    step(0, 1, 32'h3020, 32'h7f20, 4'b1000);
    step(0, 0, 32'h3010, 32'h0, 4'h0);
    step(0, 0, 32'h3010, 32'h0, 4'h0);
    step(0, 1, 32'h3010, 32'h0, 4'h0);
    step(0, 1, 32'h3013, 32'h7f24, 4'b0010);
    step(1, 1, 32'h3010, 32'h0, 4'h0);
    step(0, 1, 32'h3010, 32'h0, 4'h0);
    step(0, 1, 32'h3014, 32'h7f22, 4'b0100);
    pc = 32'h3000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1) == 0) begin
        if ($urandom_range(7) == 0) pc = $urandom;
        else pc = pcs[$urandom_range(7)] | 32'($urandom_range(3));
      end
      ad = acks[$urandom_range(3)] | 32'($urandom_range(3));
      be = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
      en = $urandom_range(9) != 0;
      r  = $urandom_range(299) == 0;
      step(r, en, pc, ad, be);
    end
    @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
